// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V IF stage holding the PC, driving instruction-memory word offset and the IF/ID register.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN; otherwise they read 0.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   stall                 hold PC and IF/ID this cycle
//   pc_src, branch_target redirect request and byte target (low two bits dropped)
//   imem_offset/imem_data word offset to memory, combinational instruction returned
//   pc                    current fetch PC
//   ifid_pc, ifid_pc_plus4, ifid_inst, ifid_valid   IF/ID pipeline register
//   fetch_count, stall_count, flush_count           perf counters
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0033,
  parameter int IMEM_ADDR_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic pc_src,
  input  logic [31:0] branch_target,
  output logic [IMEM_ADDR_W-1:0] imem_offset,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_inst,
  output logic ifid_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);
  logic [31:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_inst_q, ifid_inst_d, pc_plus4;
  logic ifid_valid_q, ifid_valid_d, hold;
  // redirect wins over stall; stall holds everything; otherwise advance
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    hold = pc_src | stall;
    pc_d = pc_src ? {branch_target[31:2], 2'b00} : stall ? pc_q : pc_plus4;
    ifid_pc_d = hold ? ifid_pc_q : pc_q;
    ifid_pc_plus4_d = hold ? ifid_pc_plus4_q : pc_plus4;
    ifid_inst_d = pc_src ? NOP_INST : stall ? ifid_inst_q : imem_data;
    ifid_valid_d = pc_src ? 1'b0 : stall ? ifid_valid_q : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_RESET;
      ifid_pc_q <= 32'd0;
      ifid_pc_plus4_q <= 32'd4;
      ifid_inst_q <= NOP_INST;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ifid_pc_q <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_inst_q <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end
  assign imem_offset = pc_q[IMEM_ADDR_W+1:2];
  assign pc = pc_q;
  assign ifid_pc = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_inst = ifid_inst_q;
  assign ifid_valid = ifid_valid_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, stall_count_q, flush_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_q + {31'd0, ~hold};
      stall_count_q <= stall_count_q + {31'd0, stall & ~pc_src};
      flush_count_q <= flush_count_q + {31'd0, pc_src};
    end
  end
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0033;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, pc_src = 1'b0;
  logic [31:0] branch_target = 32'd0, imem_data;
  logic [5:0] imem_offset;
  logic [31:0] pc, ifid_pc, ifid_pc_plus4, ifid_inst, fetch_count, stall_count, flush_count;
  logic ifid_valid;
  logic [31:0] mem [64];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_offset];
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .imem_offset(imem_offset), .imem_data(imem_data), .pc(pc), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count), .stall_count(stall_count), .flush_count(flush_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_if(input string tag, input logic [31:0] p, input logic [31:0] ip, input logic [31:0] inst, input logic v);
    chk({tag, ".pc"}, pc, p);
    chk({tag, ".ifid_pc"}, ifid_pc, ip);
    chk({tag, ".ifid_inst"}, ifid_inst, inst);
    chk({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, v});
  endtask
  task automatic chk_cnt(input string tag, input int f, input int s, input int fl);
    chk({tag, ".fetch"}, fetch_count, PERF ? f : 0);
    chk({tag, ".stall"}, stall_count, PERF ? s : 0);
    chk({tag, ".flush"}, flush_count, PERF ? fl : 0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hF000_0000 | i;
    mem[0] = 32'h0000_0083;
    mem[1] = 32'h0040_0103;
    mem[2] = 32'h00F0_D193;
    #1;
    step();
    step();
    chk_if("reset", 32'h0, 32'h0, NOP, 1'b0);
    chk("reset.plus4", ifid_pc_plus4, 32'h4);
    chk("reset.offset", {26'd0, imem_offset}, 32'h0);
    chk_cnt("reset", 0, 0, 0);
    rst = 1'b0;
    step();
    chk_if("seq1", 32'h4, 32'h0, 32'h0000_0083, 1'b1);
    step();
    chk_if("seq2", 32'h8, 32'h4, 32'h0040_0103, 1'b1);
    chk("seq2.plus4", ifid_pc_plus4, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if("stall", 32'h8, 32'h4, 32'h0040_0103, 1'b1);
    end
    stall = 1'b0;
    step();
    chk_if("seq3", 32'hC, 32'h8, 32'h00F0_D193, 1'b1);
    chk_cnt("seq3", 3, 3, 0);
    pc_src = 1'b1;
    branch_target = 32'h20;
    step();
    chk_if("redir", 32'h20, 32'h8, NOP, 1'b0);
    chk("redir.plus4", ifid_pc_plus4, 32'hC);
    pc_src = 1'b0;
    step();
    chk_if("redir_run", 32'h24, 32'h20, 32'hF000_0008, 1'b1);
    pc_src = 1'b1;
    stall = 1'b1;
    branch_target = 32'h13;
    step();
    chk_if("redir_stall", 32'h10, 32'h20, NOP, 1'b0);
    chk_cnt("redir_stall", 4, 3, 2);
    stall = 1'b0;
    branch_target = 32'hFC;
    step();
    chk("wrap.pre_pc", pc, 32'hFC);
    chk("wrap.pre_offset", {26'd0, imem_offset}, 32'h3F);
    pc_src = 1'b0;
    step();
    chk_if("wrap", 32'h100, 32'hFC, 32'hF000_003F, 1'b1);
    chk("wrap.offset", {26'd0, imem_offset}, 32'h0);
    chk("wrap.plus4", ifid_pc_plus4, 32'h100);
    pc_src = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    step();
    chk("wrap32.pre_pc", pc, 32'hFFFF_FFFC);
    pc_src = 1'b0;
    step();
    chk_if("wrap32", 32'h0, 32'hFFFF_FFFC, 32'hF000_003F, 1'b1);
    chk("wrap32.plus4", ifid_pc_plus4, 32'h0);
    chk_cnt("wrap32", 6, 3, 4);
    rst = 1'b1;
    stall = 1'b1;
    pc_src = 1'b1;
    branch_target = 32'h40;
    step();
    chk_if("rst_over", 32'h0, 32'h0, NOP, 1'b0);
    chk("rst_over.plus4", ifid_pc_plus4, 32'h4);
    chk_cnt("rst_over", 0, 0, 0);
    rst = 1'b0;
    pc_src = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) step();
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    step();
    step();
    pc_src = 1'b1;
    branch_target = 32'h0;
    step();
    pc_src = 1'b0;
    chk_cnt("perf", 5, 2, 1);
    chk_if("perf", 32'h0, 32'h10, NOP, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk_cnt("perf_rst", 0, 0, 0);
    rst = 1'b0;
    step();
    chk_cnt("perf_after", 1, 0, 0);
    chk_if("perf_after", 32'h4, 32'h0, 32'h0000_0083, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RISC-V pipeline. Holds the PC and drives the word offset into the 64-entry instruction memory. Captures the returned instruction into the IF/ID pipeline register. Handles load-use stalls from the hazard unit and branch redirects/flushes resolved downstream.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0033, bubble encoding (add x0,x0,x0) written into IF/ID on flush/reset.
IMEM_ADDR_W, 6, width of instruction-memory word offset (64 words).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID this cycle
pc_src  in  1  branch taken / redirect request from downstream stage
branch_target  in  32  redirect byte address
imem_offset  out  IMEM_ADDR_W  word offset to instruction memory = pc[IMEM_ADDR_W+1:2]
imem_data  in  32  combinational instruction read for imem_offset
pc  out  32  current fetch PC
ifid_pc  out  32  PC of instruction in IF/ID
ifid_pc_plus4  out  32  ifid_pc + 4
ifid_inst  out  32  instruction in IF/ID
ifid_valid  out  1  1 = IF/ID holds a real fetched instruction, 0 = bubble
fetch_count  out  32  perf counter (see Optional Feature)
stall_count  out  32  perf counter
flush_count  out  32  perf counter

Behaviour:
- Memory read is combinational: imem_offset derived from current pc, imem_data sampled same cycle; fetch-to-IF/ID latency 1 clock.
- Per-edge priority: rst > pc_src > stall > normal advance.
- rst=1: pc<=PC_RESET; ifid_pc<=0; ifid_pc_plus4<=4; ifid_inst<=NOP_INST; ifid_valid<=0. Reset mid-stall or mid-redirect overrides both. First cycle after rst deasserts fetches word 0.
- pc_src=1 (redirect/flush): pc<={branch_target[31:2],2'b00} (low bits forced to zero, no trap); IF/ID<=bubble (inst=NOP_INST, valid=0, ifid_pc/plus4 hold previous values). stall ignored this cycle.
- stall=1, pc_src=0: pc and all IF/ID outputs hold exactly; no fetch consumed. Multi-cycle stalls hold indefinitely.
- Normal: pc<=pc+4 (32-bit modulo, wraps 0xFFFF_FFFC->0); ifid_pc<=pc; ifid_pc_plus4<=pc+4; ifid_inst<=imem_data; ifid_valid<=1.
- Offset wrap: pc beyond 0xFC aliases; pc=0x100 drives imem_offset=0. No out-of-range detection.
- Effective mode per cycle: RESET / REDIRECT / STALL / RUN as per priority above; no other state beyond registers.
- All outputs registered except imem_offset (combinational from pc register).

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: three 32-bit counters, cleared on rst, wrap on overflow. fetch_count +1 on each normal-advance edge (ifid_valid loaded 1). stall_count +1 on each edge with stall=1, pc_src=0. flush_count +1 on each edge with pc_src=1.
- Not defined: counters not implemented; fetch_count, stall_count, flush_count tied to 0. Ports exist in both builds.

Test Plan:
- Reset + sequential: imem preloaded mem[0]=32'h00000083, mem[1]=32'h00400103, mem[2]=32'h00F0D193; rst 2 cycles then release -> after edges 1,2,3: ifid_inst=00000083/00400103/00F0D193, ifid_pc=0/4/8, ifid_valid=1, pc=0x0C.
- Stall: stall=1 for 3 cycles while pc=0x8 -> pc stays 0x8, ifid_inst stays 00400103 for all 3; release -> ifid_inst=00F0D193 next edge.
- Redirect: pc_src=1, branch_target=0x20 at pc=0x0C -> next edge pc=0x20, ifid_inst=0x00000033, ifid_valid=0; following edge ifid_pc=0x20, valid=1.
- Redirect + stall same cycle, branch_target=0x13 -> pc=0x10 (aligned), IF/ID bubble, stall ignored; flush_count +1, stall_count unchanged.
- Wrap: force pc to 0xFC via redirect, run 1 cycle -> pc=0x100, imem_offset=0, ifid_pc=0xFC.
- Perf (macro defined): 5 runs, 2 stalls, 1 redirect after reset -> fetch_count=5, stall_count=2, flush_count=1; rst mid-run -> all 0. Macro undefined -> all three read 0 throughout.
